// File: rtl/flit_sipo_fifo_pkg.sv
// rtl/flit_sipo_fifo_pkg.sv - shared constants, receive state enum and sizing helper
// for the flit reassembly FIFO.
package flit_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_HEIGHT  = 16;
   localparam int DEF_INWIDTH = 8;

   // Counter width for n flits; never narrower than one bit.
   function automatic int flit_cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   localparam int FLITS_PER_WORD = DEF_WIDTH / DEF_INWIDTH;
   localparam int FLIT_CNT_W     = flit_cnt_w(FLITS_PER_WORD);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } rx_state_t;

endpackage

// File: rtl/flit_sipo_fifo_if.sv
// rtl/flit_sipo_fifo_if.sv - flit input channel plus word-side read port.
// The master is the side that drives flits and pops words.
interface flit_sipo_fifo_if #(
   parameter int WIDTH   = 32,
   parameter int HEIGHT  = 16,
   parameter int INWIDTH = 8
);
   localparam int CNT_W = $clog2(HEIGHT) + 1;

   logic [INWIDTH-1:0] flit_in;
   logic               flit_valid;
   logic               flit_ready;
   logic               re;
   logic [WIDTH-1:0]   data_out;
   logic               full;
   logic               empty;
   logic [CNT_W-1:0]   count;
   logic               assembling;

   modport master (
      output flit_in, flit_valid, re,
      input  flit_ready, data_out, full, empty, count, assembling
   );

   modport slave (
      input  flit_in, flit_valid, re,
      output flit_ready, data_out, full, empty, count, assembling
   );
endinterface

// File: rtl/flit_sipo_fifo_word_fifo.sv
// rtl/flit_sipo_fifo_word_fifo.sv - word FIFO with combinational head read.
// Pointers wrap naturally at HEIGHT (power of two); the head reads as zero when empty.
module sipo_word_fifo #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      push,
   input  logic [WIDTH-1:0]          push_data,
   input  logic                      pop_req,
   output logic [WIDTH-1:0]          data_out,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(HEIGHT):0]   count
);
   localparam int PW = $clog2(HEIGHT);

   logic [WIDTH-1:0] mem_q [HEIGHT];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == (PW+1)'(HEIGHT));
   assign pop      = pop_req && !empty;
   assign count    = count_q;
   assign data_out = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the empty gate on data_out hides stale entries.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end
endmodule

// File: rtl/flit_sipo_fifo.sv
// rtl/flit_sipo_fifo.sv - reassembles MSB-first flits into words and buffers them;
// a completed word that cannot enter a full FIFO is parked in hold_q until a slot frees.
module flit_sipo_fifo
   import flit_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int HEIGHT  = DEF_HEIGHT,
   parameter int INWIDTH = DEF_INWIDTH
) (
   input  logic            clock,
   input  logic            reset,
   flit_sipo_fifo_if.slave bus
);
   localparam int FLITS = WIDTH / INWIDTH;
   localparam int CW    = flit_cnt_w(FLITS);
   localparam logic [CW-1:0] LAST_CNT = CW'(FLITS - 1);

   rx_state_t                state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [WIDTH-INWIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0]         hold_q, hold_d;

   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] push_data;
   logic             push;
   logic             can_push;
   logic             fifo_full;
   logic             fifo_empty;

   // Only the low bits of the shift register survive into a word, so only they are stored.
   assign word     = {shreg_q, bus.flit_in};
   assign can_push = !fifo_full || (bus.re && !fifo_empty);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      hold_d    = hold_q;
      push      = 1'b0;
      push_data = hold_q;
      unique case (state_q)
         COLLECT: begin
            if (bus.flit_valid) begin
               shreg_d = word[WIDTH-INWIDTH-1:0];
               if (cnt_q == LAST_CNT) begin
                  cnt_d = '0;
                  if (can_push) begin
                     push      = 1'b1;
                     push_data = word;
                  end else begin
                     hold_d  = word;
                     state_d = HOLD;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (can_push) begin
               push    = 1'b1;
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         shreg_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         hold_q  <= hold_d;
      end
   end

   sipo_word_fifo #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop_req   (bus.re),
      .data_out  (bus.data_out),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (bus.count)
   );

   assign bus.full       = fifo_full;
   assign bus.empty      = fifo_empty;
   assign bus.flit_ready = (state_q == COLLECT);
   assign bus.assembling = (cnt_q != '0);
endmodule
